// File: rtl/calc_pkg.sv
// Shared types and constants for the add/sub result display stage.
// Symbol codes index the seven-segment encoder; 0..9 are plain decimal digits.
package calc_pkg;
  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SHOW  = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] MAG_MAX = 4'd6;

  localparam logic [4:0] SYM_MINUS = 5'd10;
  localparam logic [4:0] SYM_E     = 5'd11;
  localparam logic [4:0] SYM_R     = 5'd12;
  localparam logic [4:0] SYM_BLANK = 5'd13;

  // The zero flag must agree with the magnitude, and the magnitude must be in range.
  function automatic logic result_ok(input logic [3:0] mag, input logic zero);
    return (mag <= MAG_MAX) && (zero == (mag == 4'd0));
  endfunction
endpackage

// File: rtl/calc_result_display_seg7_encode.sv
// Combinational symbol-to-segment lookup, active-high {g,f,e,d,c,b,a}.
module seg7_encode
  import calc_pkg::*;
(
  input  logic [4:0] sym,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (sym)
      5'd0:      seg = SEG_0;
      5'd1:      seg = SEG_1;
      5'd2:      seg = SEG_2;
      5'd3:      seg = SEG_3;
      5'd4:      seg = SEG_4;
      5'd5:      seg = SEG_5;
      5'd6:      seg = SEG_6;
      5'd7:      seg = 7'h07;
      5'd8:      seg = 7'h7F;
      5'd9:      seg = 7'h6F;
      SYM_MINUS: seg = SEG_MINUS;
      SYM_E:     seg = SEG_E;
      SYM_R:     seg = SEG_R;
      default:   seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/calc_result_display.sv
// Captures sign-magnitude results and shows them on a 2-digit multiplexed display.
// state | meaning
// BLANK | display dark, nothing captured since reset/clear
// SHOW  | valid result shown: left = sign, right = magnitude
// ERROR | invalid result captured: shows "Er", err high
module calc_result_display
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int HOLD_CYCLES    = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [3:0] res_mag,
  input  logic       res_sign,
  input  logic       res_zero,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);
  localparam int   RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int   HW  = $clog2(HOLD_CYCLES + 1);
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  state_t        state;
  logic [3:0]    mag_q;
  logic          sign_q;
  logic [RW-1:0] ref_cnt;
  logic          dig_sel;
  logic [HW-1:0] hold_cnt;
  logic          capture;
  logic [4:0]    sym;
  logic [6:0]    seg_raw;
  logic [1:0]    an_raw;

  assign res_ready = (hold_cnt == '0);
  assign capture   = res_valid && res_ready && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BLANK;
      mag_q  <= '0;
      sign_q <= 1'b0;
    end else if (clear) begin
      state <= BLANK;
    end else if (capture) begin
      state  <= result_ok(res_mag, res_zero) ? SHOW : ERROR;
      mag_q  <= res_mag;
      sign_q <= res_sign;
    end
  end

  // Hold timer counts down from HOLD_CYCLES; the source is throttled until it expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hold_cnt <= '0;
    else if (clear)          hold_cnt <= '0;
    else if (capture)        hold_cnt <= HW'(HOLD_CYCLES);
    else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      dig_sel <= 1'b0;
    end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      dig_sel <= ~dig_sel;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // dig_sel = 1 drives the left digit, 0 the right digit.
  always_comb begin
    sym    = SYM_BLANK;
    an_raw = 2'b00;
    case (state)
      SHOW: begin
        an_raw = dig_sel ? 2'b10 : 2'b01;
        if (dig_sel) sym = (sign_q && mag_q != 4'd0) ? SYM_MINUS : SYM_BLANK;
        else         sym = {1'b0, mag_q};
      end
      ERROR: begin
        an_raw = dig_sel ? 2'b10 : 2'b01;
        sym    = dig_sel ? SYM_E : SYM_R;
      end
      default: begin
        an_raw = 2'b00;
        sym    = SYM_BLANK;
      end
    endcase
  end

  seg7_encode u_enc (
    .sym (sym),
    .seg (seg_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{INV}};
      an  <= {2{INV}};
      err <= 1'b0;
    end else begin
      seg <= seg_raw ^ {7{INV}};
      an  <= an_raw ^ {2{INV}};
      err <= (state == ERROR);
    end
  end
endmodule
